csa_mul_sequencer: RTL

//  Iterative mantissa-multiply controller built around one shared 3:2 carry-save stage.

---
 rtl/csa_mul_sequencer.sv | 137 +++++++++++++
 1 files changed

// File: rtl/csa_mul_sequencer.sv
// Iterative unsigned multiplier: one partial product per cycle is folded into a carry-save
// sum/carry pair, which a single carry-propagate add resolves into the final product.
module csa_mul_sequencer #(
    parameter int DW_A       = 10,
    parameter int DW_B       = 10,
    parameter int EARLY_TERM = 0
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_in_valid,
    output logic                 o_in_ready,
    input  logic [DW_A-1:0]      i_op_a,
    input  logic [DW_B-1:0]      i_op_b,
    output logic                 o_out_valid,
    input  logic                 i_out_ready,
    output logic [DW_A+DW_B-1:0] o_out_prod,
    output logic                 o_busy
);

    localparam int W  = DW_A + DW_B;
    localparam int CW = $clog2(DW_B) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DW_B - 1);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        RESOLVE,
        DONE
    } state_t;

    state_t          r_state;
    state_t          w_nextState;

    logic [W-1:0]    r_a;
    logic [DW_B-1:0] r_b;
    logic [W-1:0]    r_sum;
    logic [W-1:0]    r_carry;
    logic [W-1:0]    r_prod;
    logic [CW-1:0]   r_cnt;

    logic [W-1:0]    w_pp;
    logic [W-1:0]    w_sumNext;
    logic [W-2:0]    w_maj;
    logic            w_accept;
    logic            w_lastScan;

    assign w_accept = (r_state == IDLE) && i_in_valid;

    // The carry out of the top bit is dropped, so majority only needs the low W-1 bits.
    always_comb begin
        w_pp       = r_b[0] ? (r_a << r_cnt) : '0;
        w_sumNext  = r_sum ^ r_carry ^ w_pp;
        w_maj      = (r_sum[W-2:0] & r_carry[W-2:0])
                   | (r_sum[W-2:0] & w_pp[W-2:0])
                   | (r_carry[W-2:0] & w_pp[W-2:0]);
        w_lastScan = (r_cnt == CNT_LAST)
                   || ((EARLY_TERM != 0) && ((r_b >> 1) == '0));
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_nextState = ACCUM;
                end
            end
            ACCUM: begin
                if (w_lastScan) begin
                    w_nextState = RESOLVE;
                end
            end
            RESOLVE: begin
                w_nextState = DONE;
            end
            DONE: begin
                if (i_out_ready) begin
                    w_nextState = IDLE;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    always_comb begin
        o_in_ready  = (r_state == IDLE);
        o_out_valid = (r_state == DONE);
        o_busy      = (r_state != IDLE);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= '0;
            r_cnt   <= '0;
            r_prod  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_a     <= {{DW_B{1'b0}}, i_op_a};
                        r_b     <= i_op_b;
                        r_sum   <= '0;
                        r_carry <= '0;
                        r_cnt   <= '0;
                    end
                end
                ACCUM: begin
                    r_sum   <= w_sumNext;
                    r_carry <= {w_maj, 1'b0};
                    r_b     <= r_b >> 1;
                    r_cnt   <= r_cnt + 1'b1;
                end
                RESOLVE: begin
                    r_prod <= r_sum + r_carry;
                end
                default: begin
                end
            endcase
        end
    end

    assign o_out_prod = r_prod;

endmodule
